// File: rtl/shift_arbiter.sv
// Two requesters share one 32-bit barrel shifter under round-robin arbitration.
// Each result lands in a per-requester response buffer with valid/ready handshake.
module shift_arbiter_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  input  logic             i_gnt,
  input  logic             i_rsp_ready,
  input  logic [31:0]      i_result,
  output logic             o_elig,
  output logic             o_rsp_valid,
  output logic [31:0]      o_rsp_result,
  output logic [CNT_W-1:0] o_gnt_cnt
);
  logic             r_valid;
  logic [31:0]      r_result;
  logic [CNT_W-1:0] r_cnt;

  // A full buffer can take a new grant only if it drains in the same cycle.
  assign o_elig       = i_req_valid && (!r_valid || i_rsp_ready);
  assign o_rsp_valid  = r_valid;
  assign o_rsp_result = r_result;
  assign o_gnt_cnt    = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
    end else if (i_gnt) begin
      r_valid  <= 1'b1;
      r_result <= i_result;
      r_cnt    <= r_cnt + 1'b1;
    end else if (r_valid && i_rsp_ready) begin
      r_valid  <= 1'b0;
    end
  end
endmodule

module shift_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [31:0]      req0_op1,
  input  logic [31:0]      req1_op1,
  input  logic [31:0]      req0_op2,
  input  logic [31:0]      req1_op2,
  input  logic             req0_dir,
  input  logic             req1_dir,
  input  logic             req0_arith,
  input  logic             req1_arith,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp0_result,
  output logic [31:0]      rsp1_result,
  output logic [CNT_W-1:0] gnt0_cnt,
  output logic [CNT_W-1:0] gnt1_cnt
);
  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0]            w_valid, w_rsp_ready, w_rsp_valid, w_elig, w_gnt;
  logic [NUM_REQ-1:0][31:0]      w_rsp_result;
  logic [NUM_REQ-1:0][CNT_W-1:0] w_cnt;
  logic [31:0]                   w_sh_op1, w_sh_op2, w_sh_res;
  logic                          w_sh_dir, w_sh_arith;
  logic                          r_prio;

  assign w_valid     = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};

  function automatic logic [31:0] f_shift(input logic [31:0] a, input logic [31:0] s,
                                          input logic dir, input logic arith);
    logic [31:0] r;
    if (s > 32'd31)  r = (dir && arith) ? {32{a[31]}} : 32'd0;
    else if (!dir)   r = a << s[4:0];
    else if (arith)  r = 32'($signed(a) >>> s[4:0]);
    else             r = a >> s[4:0];
    return r;
  endfunction

  // r_prio names the requester that wins when both are eligible.
  always_comb begin
    w_gnt = '0;
    if (!rst) begin
      if (w_elig[0] && (!w_elig[1] || !r_prio)) w_gnt[0] = 1'b1;
      else if (w_elig[1])                       w_gnt[1] = 1'b1;
    end
  end

  always_comb begin
    w_sh_op1   = '0;
    w_sh_op2   = '0;
    w_sh_dir   = 1'b0;
    w_sh_arith = 1'b0;
    if (w_gnt[0]) begin
      w_sh_op1 = req0_op1; w_sh_op2 = req0_op2; w_sh_dir = req0_dir; w_sh_arith = req0_arith;
    end else if (w_gnt[1]) begin
      w_sh_op1 = req1_op1; w_sh_op2 = req1_op2; w_sh_dir = req1_dir; w_sh_arith = req1_arith;
    end
  end

  assign w_sh_res = f_shift(w_sh_op1, w_sh_op2, w_sh_dir, w_sh_arith);

  always_ff @(posedge clk) begin
    if (rst)         r_prio <= 1'b0;
    else if (|w_gnt) r_prio <= w_gnt[0];
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    shift_arbiter_lane #(.CNT_W(CNT_W)) u_lane (
      .clk          (clk),
      .rst          (rst),
      .i_req_valid  (w_valid[g]),
      .i_gnt        (w_gnt[g]),
      .i_rsp_ready  (w_rsp_ready[g]),
      .i_result     (w_sh_res),
      .o_elig       (w_elig[g]),
      .o_rsp_valid  (w_rsp_valid[g]),
      .o_rsp_result (w_rsp_result[g]),
      .o_gnt_cnt    (w_cnt[g])
    );
  end

  assign req0_ready  = w_gnt[0];
  assign req1_ready  = w_gnt[1];
  assign rsp0_valid  = w_rsp_valid[0];
  assign rsp1_valid  = w_rsp_valid[1];
  assign rsp0_result = w_rsp_result[0];
  assign rsp1_result = w_rsp_result[1];
  assign gnt0_cnt    = w_cnt[0];
  assign gnt1_cnt    = w_cnt[1];
endmodule
